// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between NUM_REQ requesters.
// Tracks each operation through the ALU register and returns results tagged by requester ID.
module alu_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [3*NUM_REQ-1:0]  req_command,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    output logic                  alu_valid,
    output logic [2:0]            alu_command,
    output logic [31:0]           alu_in_a,
    output logic [31:0]           alu_in_b,
    input  logic [31:0]           alu_result,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_result
);

    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [ID_W-1:0]    s1_id_q, s1_id_d;
    logic               s2_valid_q;
    logic [ID_W-1:0]    s2_id_q;
    logic               alu_valid_q, alu_valid_d;
    logic [2:0]         alu_command_q, alu_command_d;
    logic [31:0]        alu_in_a_q, alu_in_a_d;
    logic [31:0]        alu_in_b_q, alu_in_b_d;

    logic [NUM_REQ-1:0] elig;
    logic               gnt_found;
    logic [ID_W-1:0]    gnt_id;
    logic               xfer;

    // A requester whose response returns this cycle may re-issue immediately.
    assign elig = req_valid & (~pending_q | rsp_valid);

    always_comb begin
        int unsigned idx;
        gnt_found = 1'b0;
        gnt_id    = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!gnt_found && elig[idx]) begin
                gnt_found = 1'b1;
                gnt_id    = ID_W'(idx);
            end
        end
    end

    assign xfer      = gnt_found & ~reset;
    assign req_ready = xfer ? (NUM_REQ'(1) << gnt_id) : '0;

    always_comb begin
        ptr_d         = ptr_q;
        pending_d     = pending_q;
        s1_id_d       = s1_id_q;
        alu_valid_d   = xfer;
        alu_command_d = alu_command_q;
        alu_in_a_d    = alu_in_a_q;
        alu_in_b_d    = alu_in_b_q;
        // Clear before set so a same-cycle re-grant keeps the bit high.
        if (s2_valid_q) begin
            pending_d[s2_id_q] = 1'b0;
        end
        if (xfer) begin
            ptr_d              = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
            pending_d[gnt_id]  = 1'b1;
            s1_id_d            = gnt_id;
            alu_command_d      = req_command[3*gnt_id +: 3];
            alu_in_a_d         = req_a[32*gnt_id +: 32];
            alu_in_b_d         = req_b[32*gnt_id +: 32];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q         <= '0;
            pending_q     <= '0;
            s1_id_q       <= '0;
            s2_valid_q    <= 1'b0;
            s2_id_q       <= '0;
            alu_valid_q   <= 1'b0;
            alu_command_q <= '0;
            alu_in_a_q    <= '0;
            alu_in_b_q    <= '0;
        end else begin
            ptr_q         <= ptr_d;
            pending_q     <= pending_d;
            s1_id_q       <= s1_id_d;
            s2_valid_q    <= alu_valid_q;
            s2_id_q       <= s1_id_q;
            alu_valid_q   <= alu_valid_d;
            alu_command_q <= alu_command_d;
            alu_in_a_q    <= alu_in_a_d;
            alu_in_b_q    <= alu_in_b_d;
        end
    end

    assign alu_valid   = alu_valid_q;
    assign alu_command = alu_command_q;
    assign alu_in_a    = alu_in_a_q;
    assign alu_in_b    = alu_in_b_q;

    assign rsp_valid  = s2_valid_q ? (NUM_REQ'(1) << s2_id_q) : '0;
    assign rsp_id     = s2_id_q;
    assign rsp_result = alu_result;

endmodule
